// File: rtl/calc_pkg.sv
// calc_pkg: shared types and constants for the add/sub calculator
package calc_pkg;
  localparam int DATA_W = 8;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  typedef enum logic [1:0] {
    WAIT_A = 2'd0,
    WAIT_B = 2'd1,
    EXEC   = 2'd2,
    SHOW   = 2'd3
  } phase_t;
endpackage

// File: rtl/calc_addsub8.sv
// calc_addsub8: combinational ripple-carry adder/subtractor with status flags
module calc_addsub8
  import calc_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  output logic [DATA_W-1:0] s,
  output logic              cout,
  output logic              ovr,
  output logic              zero,
  output logic              neg
);
  logic [DATA_W:0]   c;
  logic [DATA_W-1:0] bx;
  assign bx = b ^ {DATA_W{sub}};
  // ripple the carry chain bit by bit; subtract is A + ~B + 1
  always_comb begin
    s = '0;
    c = '0;
    c[0] = (sub == OP_SUB);
    for (int i = 0; i < DATA_W; i++) begin
      s[i]   = a[i] ^ bx[i] ^ c[i];
      c[i+1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end
  end
  assign cout = c[DATA_W];
  assign ovr  = c[DATA_W] ^ c[DATA_W-1];
  assign zero = (s == '0);
  assign neg  = s[DATA_W-1];
endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: operand capture, add/sub execution and chaining controller
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              enter,
  input  logic              op,
  input  logic              clear,
  output logic [DATA_W-1:0] result,
  output logic              cout,
  output logic              ovr,
  output logic              zero,
  output logic              neg,
  output logic              valid,
  output logic [1:0]        phase,
  output logic [7:0]        op_count
);
  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   enter_pulse;
  phase_t                 state;
  phase_t                 next;
  logic [DATA_W-1:0]      a_reg;
  logic [DATA_W-1:0]      b_reg;
  logic                   op_reg;
  logic [DATA_W-1:0]      core_s;
  logic                   core_cout;
  logic                   core_ovr;
  logic                   core_zero;
  logic                   core_neg;
  calc_addsub8 u_core (
    .a    (a_reg),
    .b    (b_reg),
    .sub  (op_reg),
    .s    (core_s),
    .cout (core_cout),
    .ovr  (core_ovr),
    .zero (core_zero),
    .neg  (core_neg)
  );
  // synchronize the async enter level and remember its last value for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], enter};
      prev <= sync[SYNC_STAGES-1];
    end
  end
  assign enter_pulse = sync[SYNC_STAGES-1] & ~prev;
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_A;
    else        state <= next;
  end
  // next state: clear wins, EXEC always moves on to SHOW
  always_comb begin
    next = clear             ? WAIT_A :
           (state == WAIT_A) ? (enter_pulse ? WAIT_B : WAIT_A) :
           (state == WAIT_B) ? (enter_pulse ? EXEC : WAIT_B) :
           (state == EXEC)   ? SHOW :
                               (enter_pulse ? EXEC : SHOW);
  end
  // operand capture, result/flag registration and completed-op counting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      op_reg   <= OP_ADD;
      result   <= '0;
      cout     <= 1'b0;
      ovr      <= 1'b0;
      zero     <= 1'b0;
      neg      <= 1'b0;
      valid    <= 1'b0;
      op_count <= '0;
    end else if (clear) begin
      a_reg  <= '0;
      b_reg  <= '0;
      op_reg <= OP_ADD;
      result <= '0;
      cout   <= 1'b0;
      ovr    <= 1'b0;
      zero   <= 1'b0;
      neg    <= 1'b0;
      valid  <= 1'b0;
    end else begin
      if (state == WAIT_A && enter_pulse) a_reg <= din;
      if (state == WAIT_B && enter_pulse) begin
        b_reg  <= din;
        op_reg <= op;
      end
      if (state == EXEC) begin
        result   <= core_s;
        cout     <= core_cout;
        ovr      <= core_ovr;
        zero     <= core_zero;
        neg      <= core_neg;
        valid    <= 1'b1;
        op_count <= op_count + 8'd1;
      end
      if (state == SHOW && enter_pulse) begin
        a_reg  <= result;
        b_reg  <= din;
        op_reg <= op;
        valid  <= 1'b0;
      end
    end
  end
  assign phase = state;
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed scoreboard bench for the calculator sequencer
module tb_calc_sequencer;
  import calc_pkg::*;
  localparam int S = 2;
  typedef struct packed {
    logic [7:0] r;
    logic       c;
    logic       o;
    logic       z;
    logic       n;
    logic [7:0] cnt;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       enter;
  logic       op;
  logic       clear;
  logic [7:0] result;
  logic       cout;
  logic       ovr;
  logic       zero;
  logic       neg;
  logic       valid;
  logic [1:0] phase;
  logic [7:0] op_count;
  int   n_cmp = 0;
  int   n_err = 0;
  int   m_cmp = 0;
  int   m_err = 0;
  exp_t sbq[$];
  logic vprev = 1'b0;
  logic [7:0] exp_cnt = 8'd0;
  logic [7:0] pr;
  calc_sequencer #(.SYNC_STAGES(S)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .enter    (enter),
    .op       (op),
    .clear    (clear),
    .result   (result),
    .cout     (cout),
    .ovr      (ovr),
    .zero     (zero),
    .neg      (neg),
    .valid    (valid),
    .phase    (phase),
    .op_count (op_count)
  );
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
    $fatal(1, "watchdog");
  end
  // monitor: every rising edge of valid presents one result to the scoreboard
  initial forever begin
    exp_t e;
    exp_t g;
    @(negedge clk);
    if (valid && !vprev) begin
      m_cmp++;
      g = {result, cout, ovr, zero, neg, op_count};
      if (sbq.size() == 0) begin
        m_err++;
        $display("FAIL sb_unexpected: got result %02h with no expected entry", result);
      end else begin
        e = sbq.pop_front();
        if (g !== e)
          begin
            m_err++;
            $display("FAIL sb_result: got r=%02h c=%0d o=%0d z=%0d n=%0d cnt=%02h, want r=%02h c=%0d o=%0d z=%0d n=%0d cnt=%02h",
                     g.r, g.c, g.o, g.z, g.n, g.cnt, e.r, e.c, e.o, e.z, e.n, e.cnt);
          end
      end
    end
    vprev = valid;
  end
  function automatic exp_t mk(input logic [7:0] r, input logic c, input logic o,
                              input logic z, input logic n, input logic [7:0] cnt);
    mk = {r, c, o, z, n, cnt};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, want);
    end
  endtask
  task automatic press(input logic [7:0] d, input logic o);
    logic [1:0] p0;
    bit done;
    done = 0;
    enter = 1'b0;
    repeat (S + 1) @(negedge clk);
    p0 = phase;
    din = d;
    op = o;
    enter = 1'b1;
    for (int i = 1; i <= S + 4 && !done; i++) begin
      @(negedge clk);
      if (phase != p0) begin
        done = 1;
        chk("commit_lat", i, S + 1);
      end
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL commit_timeout: got phase %0d unchanged, want a transition", phase);
    end
    enter = 1'b0;
  endtask
  task automatic op_b(input logic [7:0] d, input logic o, input exp_t e);
    sbq.push_back(e);
    press(d, o);
    chk("exec_phase", phase, EXEC);
    chk("exec_valid", valid, 0);
    @(negedge clk);
    chk("show_phase", phase, SHOW);
    chk("show_valid", valid, 1);
  endtask
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic o, input exp_t e);
    press(a, OP_ADD);
    chk("a_phase", phase, WAIT_B);
    op_b(b, o, e);
  endtask
  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_result", result, 0);
    chk("clr_flags", {cout, ovr, zero, neg, valid}, 0);
    chk("clr_phase", phase, WAIT_A);
    chk("clr_count", op_count, exp_cnt);
  endtask
  initial begin
    rst_n = 1'b0;
    enter = 1'b0;
    din = 8'h00;
    op = 1'b0;
    clear = 1'b0;
    repeat (3) begin
      @(negedge clk);
      enter = ~enter;
      din = din + 8'h5A;
    end
    chk("rst_result", result, 0);
    chk("rst_flags", {cout, ovr, zero, neg, valid}, 0);
    chk("rst_phase", phase, 0);
    chk("rst_count", op_count, 0);
    enter = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rel_phase", phase, WAIT_A);
    chk("rel_valid", valid, 0);
    // enter held 20 cycles in WAIT_A: only the first din is captured as A
    repeat (S + 1) @(negedge clk);
    din = 8'h05;
    enter = 1'b1;
    repeat (5) @(negedge clk);
    din = 8'h33;
    repeat (15) @(negedge clk);
    chk("hold_phase", phase, WAIT_B);
    enter = 1'b0;
    op_b(8'h03, OP_ADD, mk(8'h08, 0, 0, 0, 0, 8'd1));
    op_b(8'h02, OP_SUB, mk(8'h06, 1, 0, 0, 0, 8'd2));
    exp_cnt = 8'd2;
    do_clear();
    do_op(8'h7F, 8'h01, OP_ADD, mk(8'h80, 0, 1, 0, 1, 8'd3));
    exp_cnt = 8'd3;
    do_clear();
    do_op(8'hFF, 8'h01, OP_ADD, mk(8'h00, 1, 0, 1, 0, 8'd4));
    exp_cnt = 8'd4;
    do_clear();
    do_op(8'h05, 8'h05, OP_SUB, mk(8'h00, 1, 0, 1, 0, 8'd5));
    exp_cnt = 8'd5;
    do_clear();
    do_op(8'h03, 8'h05, OP_SUB, mk(8'hFE, 0, 0, 0, 1, 8'd6));
    exp_cnt = 8'd6;
    do_clear();
    do_op(8'h80, 8'h01, OP_SUB, mk(8'h7F, 1, 1, 0, 0, 8'd7));
    exp_cnt = 8'd7;
    do_clear();
    // clear lands in the same cycle as the WAIT_B enter pulse
    press(8'h44, OP_ADD);
    chk("cc_a_phase", phase, WAIT_B);
    repeat (S + 1) @(negedge clk);
    din = 8'h99;
    op = 1'b1;
    enter = 1'b1;
    repeat (S) @(negedge clk);
    chk("cc_pulse_align", dut.enter_pulse, 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    enter = 1'b0;
    chk("cc_phase", phase, WAIT_A);
    chk("cc_b_reg", dut.b_reg, 0);
    chk("cc_count", op_count, 7);
    repeat (4) @(negedge clk);
    chk("cc_phase_stay", phase, WAIT_A);
    // asynchronous reset asserted while in EXEC
    press(8'h10, OP_ADD);
    press(8'h20, OP_ADD);
    chk("re_exec", phase, EXEC);
    rst_n = 1'b0;
    #1;
    chk("re_phase", phase, 0);
    chk("re_count", op_count, 0);
    chk("re_out", {result, cout, ovr, zero, neg, valid}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 8'd0;
    repeat (2) @(negedge clk);
    // 256 operations: the count must wrap to zero
    do_op(8'h00, 8'h01, OP_ADD, mk(8'h01, 0, 0, 0, 0, 8'd1));
    pr = 8'h01;
    for (int i = 2; i <= 256; i++) begin
      logic [8:0] s9;
      s9 = {1'b0, pr} + 9'd1;
      op_b(8'h01, OP_ADD, mk(s9[7:0], s9[8], pr == 8'h7F, s9[7:0] == 8'h00, s9[7], i[7:0]));
      pr = s9[7:0];
    end
    chk("wrap_count", op_count, 0);
    chk("wrap_result", result, 0);
    repeat (3) @(negedge clk);
    chk("sb_drain", sbq.size(), 0);
    n_cmp += m_cmp;
    n_err += m_err;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
